// File: rtl/noc_traffic_endpoint.sv
// noc_traffic_endpoint
// Traffic endpoint for one NoC node's local port.
//   Generator: on a start pulse it latches cfg_* and injects cfg_num_pkts
//   packets of cfg_len flits (head/body/tail) to cfg_dest. It leaves
//   cfg_gap idle cycles between packets.
//   Checker: consumes ejected flits, counts flits and tails, and raises a
//   sticky rx_error on framing or destination violations.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, cfg_*        run control and configuration (sampled in IDLE only)
//   tx_data/valid/ready injection handshake (tx_data, tx_valid registered)
//   rx_data/valid/ready ejection handshake; rx_ready = ~rx_stall
//   busy, done          run in progress / one-cycle end-of-run pulse
//   tx_pkt_count        packets sent in the current run
//   rx_pkt_count        tails received since reset
//   rx_flit_count       flits received since reset
//   rx_error            sticky error flag
module noc_traffic_endpoint #(
  parameter int DATA_WIDTH = 32,
  parameter int NODE_ID    = 0,
  parameter int DEST_WIDTH = 3,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_num_pkts,
  input  logic [LEN_WIDTH-1:0]  cfg_gap,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  rx_stall,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  tx_pkt_count,
  output logic [CNT_WIDTH-1:0]  rx_pkt_count,
  output logic [CNT_WIDTH-1:0]  rx_flit_count,
  output logic                  rx_error
);

  typedef enum logic [1:0] {GEN_IDLE, GEN_SEND, GEN_GAP, GEN_FIN} gen_state_e;
  typedef enum logic {RX_EXPECT_HEAD, RX_IN_PKT} rx_state_e;

  localparam logic [1:0] TYPE_INVALID = 2'd0;
  localparam logic [1:0] TYPE_HEAD    = 2'd1;
  localparam logic [1:0] TYPE_BODY    = 2'd2;
  localparam logic [1:0] TYPE_TAIL    = 2'd3;

  localparam logic [7:0]            NODE_ID8  = 8'(NODE_ID);
  localparam logic [DEST_WIDTH-1:0] NODE_DEST = DEST_WIDTH'(NODE_ID);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_TWO   = LEN_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  gen_state_e gen_state_q, gen_state_d;
  rx_state_e  rx_state_q, rx_state_d;

  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [LEN_WIDTH-1:0]  gap_q, gap_d;
  logic [LEN_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [LEN_WIDTH-1:0]  flit_idx_q, flit_idx_d;
  logic [CNT_WIDTH-1:0]  tx_pkt_count_q, tx_pkt_count_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;

  logic [CNT_WIDTH-1:0]  rx_pkt_count_q, rx_pkt_count_d;
  logic [CNT_WIDTH-1:0]  rx_flit_count_q, rx_flit_count_d;
  logic                  rx_error_q, rx_error_d;

  logic                  tx_fire;
  logic                  rx_fire;
  logic [1:0]            rx_type;
  logic [LEN_WIDTH-1:0]  start_len;
  logic [CNT_WIDTH-1:0]  pkt_next;
  logic                  rx_data_unused;

  // Builds flit number f of a packet of length len. Head flits carry only
  // the destination; body/tail flits carry source, sequence and index.
  function automatic logic [DATA_WIDTH-1:0] make_flit(
    input logic [LEN_WIDTH-1:0]  f,
    input logic [LEN_WIDTH-1:0]  len,
    input logic [CNT_WIDTH-1:0]  seq,
    input logic [DEST_WIDTH-1:0] dest
  );
    logic [DATA_WIDTH-1:0] flit;
    flit = '0;
    if (f == LEN_ONE) begin
      flit[DATA_WIDTH-1 -: 2] = TYPE_HEAD;
      flit[DEST_WIDTH-1:0]    = dest;
    end else begin
      flit[DATA_WIDTH-1 -: 2] = (f == len) ? TYPE_TAIL : TYPE_BODY;
      flit[23:16]             = NODE_ID8;
      flit[15:8]              = seq[7:0];
      flit[7:0]               = 8'(f);
    end
    return flit;
  endfunction

  assign tx_fire   = tx_valid_q & tx_ready;
  assign start_len = (cfg_len < LEN_TWO) ? LEN_TWO : cfg_len;
  assign pkt_next  = tx_pkt_count_q + CNT_ONE;

  // Generator next-state. tx_data/tx_valid are computed one cycle ahead so
  // the outputs come straight from flops and hold until the handshake.
  always_comb begin
    gen_state_d    = gen_state_q;
    dest_d         = dest_q;
    len_d          = len_q;
    num_d          = num_q;
    gap_d          = gap_q;
    gap_cnt_d      = gap_cnt_q;
    flit_idx_d     = flit_idx_q;
    tx_pkt_count_d = tx_pkt_count_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;

    case (gen_state_q)
      GEN_IDLE: begin
        if (start) begin
          dest_d         = cfg_dest;
          len_d          = start_len;
          num_d          = cfg_num_pkts;
          gap_d          = cfg_gap;
          tx_pkt_count_d = '0;
          flit_idx_d     = LEN_ONE;
          if (cfg_num_pkts == '0) begin
            gen_state_d = GEN_FIN;
          end else begin
            gen_state_d = GEN_SEND;
            tx_valid_d  = 1'b1;
            tx_data_d   = make_flit(LEN_ONE, start_len, '0, cfg_dest);
          end
        end
      end
      GEN_SEND: begin
        if (tx_fire) begin
          if (flit_idx_q == len_q) begin
            tx_pkt_count_d = pkt_next;
            flit_idx_d     = LEN_ONE;
            if (pkt_next == num_q) begin
              gen_state_d = GEN_FIN;
              tx_valid_d  = 1'b0;
              tx_data_d   = '0;
            end else if (gap_q == '0) begin
              tx_valid_d = 1'b1;
              tx_data_d  = make_flit(LEN_ONE, len_q, pkt_next, dest_q);
            end else begin
              gen_state_d = GEN_GAP;
              gap_cnt_d   = gap_q;
              tx_valid_d  = 1'b0;
              tx_data_d   = '0;
            end
          end else begin
            flit_idx_d = flit_idx_q + LEN_ONE;
            tx_data_d  = make_flit(flit_idx_q + LEN_ONE, len_q, tx_pkt_count_q, dest_q);
          end
        end
      end
      GEN_GAP: begin
        // gap_cnt starts at cfg_gap, so the head appears after exactly
        // cfg_gap idle cycles.
        if (gap_cnt_q == LEN_ONE) begin
          gen_state_d = GEN_SEND;
          tx_valid_d  = 1'b1;
          tx_data_d   = make_flit(LEN_ONE, len_q, tx_pkt_count_q, dest_q);
        end else begin
          gap_cnt_d = gap_cnt_q - LEN_ONE;
        end
      end
      GEN_FIN: begin
        gen_state_d = GEN_IDLE;
      end
      default: begin
        gen_state_d = GEN_IDLE;
      end
    endcase
  end

  assign rx_ready = ~rx_stall;
  assign rx_fire  = rx_valid & ~rx_stall;
  assign rx_type  = rx_data[DATA_WIDTH-1 -: 2];
  // Payload bits are not inspected by the checker.
  assign rx_data_unused = ^rx_data[DATA_WIDTH-3:DEST_WIDTH];

  // Framing checker next-state.
  always_comb begin
    rx_state_d      = rx_state_q;
    rx_pkt_count_d  = rx_pkt_count_q;
    rx_flit_count_d = rx_flit_count_q;
    rx_error_d      = rx_error_q;

    if (rx_fire) begin
      rx_flit_count_d = rx_flit_count_q + CNT_ONE;
      case (rx_type)
        TYPE_INVALID: rx_error_d = 1'b1;
        TYPE_HEAD: begin
          if (rx_state_q == RX_EXPECT_HEAD) begin
            rx_state_d = RX_IN_PKT;
            if (rx_data[DEST_WIDTH-1:0] != NODE_DEST) rx_error_d = 1'b1;
          end else begin
            // Head inside a packet: flag it and treat it as a new packet.
            rx_error_d = 1'b1;
          end
        end
        TYPE_BODY: begin
          if (rx_state_q == RX_EXPECT_HEAD) rx_error_d = 1'b1;
        end
        TYPE_TAIL: begin
          if (rx_state_q == RX_EXPECT_HEAD) begin
            rx_error_d = 1'b1;
          end else begin
            rx_pkt_count_d = rx_pkt_count_q + CNT_ONE;
            rx_state_d     = RX_EXPECT_HEAD;
          end
        end
        default: rx_error_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_state_q     <= GEN_IDLE;
      dest_q          <= '0;
      len_q           <= '0;
      num_q           <= '0;
      gap_q           <= '0;
      gap_cnt_q       <= '0;
      flit_idx_q      <= '0;
      tx_pkt_count_q  <= '0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      rx_state_q      <= RX_EXPECT_HEAD;
      rx_pkt_count_q  <= '0;
      rx_flit_count_q <= '0;
      rx_error_q      <= 1'b0;
    end else begin
      gen_state_q     <= gen_state_d;
      dest_q          <= dest_d;
      len_q           <= len_d;
      num_q           <= num_d;
      gap_q           <= gap_d;
      gap_cnt_q       <= gap_cnt_d;
      flit_idx_q      <= flit_idx_d;
      tx_pkt_count_q  <= tx_pkt_count_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      rx_state_q      <= rx_state_d;
      rx_pkt_count_q  <= rx_pkt_count_d;
      rx_flit_count_q <= rx_flit_count_d;
      rx_error_q      <= rx_error_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign busy          = (gen_state_q != GEN_IDLE);
  assign done          = (gen_state_q == GEN_FIN);
  assign tx_pkt_count  = tx_pkt_count_q;
  assign rx_pkt_count  = rx_pkt_count_q;
  assign rx_flit_count = rx_flit_count_q;
  assign rx_error      = rx_error_q;

endmodule

// File: tb/tb_noc_traffic_endpoint.sv
// Directed testbench for noc_traffic_endpoint with NODE_ID = 5.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_noc_traffic_endpoint;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  cfgDest;
   logic [7:0]  cfgLen;
   logic [15:0] cfgNumPkts;
   logic [7:0]  cfgGap;
   logic [31:0] txData;
   logic        txValid;
   logic        txReady;
   logic [31:0] rxData;
   logic        rxValid;
   logic        rxReady;
   logic        rxStall;
   logic        busy;
   logic        done;
   logic [15:0] txPktCount;
   logic [15:0] rxPktCount;
   logic [15:0] rxFlitCount;
   logic        rxError;

   logic        loopback;
   logic [31:0] drvRxData;
   logic        drvRxValid;

   int errors;
   int checks;
   int idleCycles;

   // Expected flits for the len=4 run under alternating tx_ready, by cycle.
   logic [31:0] stallExp [7];

   noc_traffic_endpoint #(
      .DATA_WIDTH(32),
      .NODE_ID(5),
      .DEST_WIDTH(3),
      .LEN_WIDTH(8),
      .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .cfg_dest(cfgDest),
      .cfg_len(cfgLen),
      .cfg_num_pkts(cfgNumPkts),
      .cfg_gap(cfgGap),
      .tx_data(txData),
      .tx_valid(txValid),
      .tx_ready(txReady),
      .rx_data(rxData),
      .rx_valid(rxValid),
      .rx_ready(rxReady),
      .rx_stall(rxStall),
      .busy(busy),
      .done(done),
      .tx_pkt_count(txPktCount),
      .rx_pkt_count(rxPktCount),
      .rx_flit_count(rxFlitCount),
      .rx_error(rxError)
   );

   // Loopback routes injected flits straight back into the checker.
   assign rxData  = loopback ? txData  : drvRxData;
   assign rxValid = loopback ? txValid : drvRxValid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Pulses start for one cycle with the given configuration; returns in
   // the first cycle after the start edge.
   task automatic applyStimulus(input logic [2:0] dest, input logic [7:0] len,
                                input logic [15:0] num, input logic [7:0] gap);
      cfgDest    = dest;
      cfgLen     = len;
      cfgNumPkts = num;
      cfgGap     = gap;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; start = 1'b0; cfgDest = '0; cfgLen = '0; cfgNumPkts = '0; cfgGap = '0;
      txReady = 1'b0; rxStall = 1'b0; loopback = 1'b0; drvRxData = '0; drvRxValid = 1'b0;
      stallExp = '{32'h40000005, 32'h80050002, 32'h80050002, 32'h80050003,
                   32'h80050003, 32'hC0050004, 32'hC0050004};

      // Reset state
      tick();
      tick();
      checkOutput("rst_tx_valid", {31'd0, txValid}, 32'd0);
      checkOutput("rst_tx_data", txData, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_rx_ready", {31'd0, rxReady}, 32'd1);
      checkOutput("rst_rx_flits", {16'd0, rxFlitCount}, 32'd0);
      rst = 1'b0;
      tick();

      // Loopback: two packets of 6 flits, full throughput
      $display("[TB] loopback run");
      loopback = 1'b1;
      txReady  = 1'b1;
      applyStimulus(3'd5, 8'd6, 16'd2, 8'd0);
      checkOutput("lb_first_valid", {31'd0, txValid}, 32'd1);
      checkOutput("lb_first_head", txData, 32'h40000005);
      checkOutput("lb_busy", {31'd0, busy}, 32'd1);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1)  checkOutput("lb_p0_body2", txData, 32'h80050002);
         if (k == 5)  checkOutput("lb_p0_tail", txData, 32'hC0050006);
         if (k == 6)  checkOutput("lb_p1_head", txData, 32'h40000005);
         if (k == 7)  checkOutput("lb_p1_body2", txData, 32'h80050102);
         if (k == 11) checkOutput("lb_p1_tail", txData, 32'hC0050106);
         if (k == 11) checkOutput("lb_done_early", {31'd0, done}, 32'd0);
      end
      checkOutput("lb_done", {31'd0, done}, 32'd1);
      checkOutput("lb_valid_fin", {31'd0, txValid}, 32'd0);
      checkOutput("lb_tx_pkts", {16'd0, txPktCount}, 32'd2);
      tick();
      checkOutput("lb_done_pulse", {31'd0, done}, 32'd0);
      checkOutput("lb_busy_end", {31'd0, busy}, 32'd0);
      checkOutput("lb_rx_pkts", {16'd0, rxPktCount}, 32'd2);
      checkOutput("lb_rx_flits", {16'd0, rxFlitCount}, 32'd12);
      checkOutput("lb_rx_error", {31'd0, rxError}, 32'd0);
      checkOutput("lb_tx_pkts_hold", {16'd0, txPktCount}, 32'd2);
      loopback = 1'b0;

      // Alternating tx_ready, len=4; a start pulse mid-run must be ignored
      $display("[TB] tx_ready toggling run");
      txReady = 1'b0;
      applyStimulus(3'd5, 8'd4, 16'd1, 8'd0);
      for (int k = 1; k <= 7; k++) begin
         txReady = k[0];
         start   = (k == 3);
         if (k == 3) cfgNumPkts = 16'd5;
         checkOutput($sformatf("stall_valid_c%0d", k), {31'd0, txValid}, 32'd1);
         checkOutput($sformatf("stall_data_c%0d", k), txData, stallExp[k-1]);
         tick();
      end
      start   = 1'b0;
      txReady = 1'b1;
      checkOutput("stall_done", {31'd0, done}, 32'd1);
      checkOutput("stall_valid_fin", {31'd0, txValid}, 32'd0);
      checkOutput("stall_tx_pkts", {16'd0, txPktCount}, 32'd1);
      tick();
      checkOutput("stall_busy_end", {31'd0, busy}, 32'd0);

      // Gap of 3 idle cycles between packets
      $display("[TB] gap run");
      applyStimulus(3'd5, 8'd2, 16'd2, 8'd3);
      checkOutput("gap_p0_head", txData, 32'h40000005);
      tick();
      checkOutput("gap_p0_tail", txData, 32'hC0050002);
      tick();
      checkOutput("gap_busy", {31'd0, busy}, 32'd1);
      idleCycles = 0;
      while (txValid == 1'b0 && idleCycles < 20) begin
         idleCycles++;
         tick();
      end
      checkOutput("gap_idle_cycles", idleCycles, 32'd3);
      checkOutput("gap_p1_head", txData, 32'h40000005);
      tick();
      checkOutput("gap_p1_tail", txData, 32'hC0050102);
      tick();
      checkOutput("gap_done", {31'd0, done}, 32'd1);
      tick();

      // Zero packets, then a len=1 packet (treated as len 2)
      $display("[TB] zero-packet and short-packet runs");
      applyStimulus(3'd5, 8'd1, 16'd0, 8'd0);
      checkOutput("zero_done", {31'd0, done}, 32'd1);
      checkOutput("zero_valid", {31'd0, txValid}, 32'd0);
      checkOutput("zero_tx_pkts", {16'd0, txPktCount}, 32'd0);
      tick();
      checkOutput("zero_done_pulse", {31'd0, done}, 32'd0);
      checkOutput("zero_busy", {31'd0, busy}, 32'd0);
      applyStimulus(3'd5, 8'd1, 16'd1, 8'd0);
      checkOutput("short_head", txData, 32'h40000005);
      tick();
      checkOutput("short_tail", txData, 32'hC0050002);
      tick();
      checkOutput("short_done", {31'd0, done}, 32'd1);
      checkOutput("short_tx_pkts", {16'd0, txPktCount}, 32'd1);
      tick();

      // Driven rx: stray body, stall, wrong destination
      $display("[TB] driven rx checks");
      drvRxData  = 32'h80050002;
      drvRxValid = 1'b1;
      tick();
      drvRxValid = 1'b0;
      checkOutput("rx_body_error", {31'd0, rxError}, 32'd1);
      checkOutput("rx_body_pkts", {16'd0, rxPktCount}, 32'd2);
      checkOutput("rx_body_flits", {16'd0, rxFlitCount}, 32'd13);
      rxStall = 1'b1;
      #1;
      checkOutput("rx_stall_ready", {31'd0, rxReady}, 32'd0);
      drvRxData  = 32'h40000005;
      drvRxValid = 1'b1;
      tick();
      tick();
      checkOutput("rx_stall_flits", {16'd0, rxFlitCount}, 32'd13);
      checkOutput("rx_stall_pkts", {16'd0, rxPktCount}, 32'd2);
      drvRxValid = 1'b0;
      rxStall    = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rx_error_cleared", {31'd0, rxError}, 32'd0);
      drvRxData  = 32'h40000004;
      drvRxValid = 1'b1;
      tick();
      drvRxValid = 1'b0;
      checkOutput("rx_dest_error", {31'd0, rxError}, 32'd1);
      checkOutput("rx_dest_flits", {16'd0, rxFlitCount}, 32'd1);

      // Asynchronous reset during the third flit of the second packet
      $display("[TB] reset mid-packet");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      txReady = 1'b1;
      applyStimulus(3'd5, 8'd4, 16'd2, 8'd0);
      for (int k = 1; k <= 6; k++) tick();
      checkOutput("mid_p1_f3", txData, 32'h80050103);
      checkOutput("mid_tx_pkts", {16'd0, txPktCount}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("arst_tx_valid", {31'd0, txValid}, 32'd0);
      checkOutput("arst_tx_data", txData, 32'd0);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_tx_pkts", {16'd0, txPktCount}, 32'd0);
      checkOutput("arst_rx_ready", {31'd0, rxReady}, 32'd1);
      tick();
      rst = 1'b0;
      applyStimulus(3'd5, 8'd4, 16'd1, 8'd0);
      checkOutput("fresh_head", txData, 32'h40000005);
      tick();
      checkOutput("fresh_body_seq0", txData, 32'h80050002);
      checkOutput("fresh_tx_pkts", {16'd0, txPktCount}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/noc_traffic_endpoint.md
Name: noc_traffic_endpoint

Overview:
Parametrised, synthesizable traffic endpoint attached to one NoC node's local port. A configurable packet generator injects head/body/tail flit packets into the router over a valid/ready handshake. A framing checker consumes ejected flits, counts packets and flags protocol errors. It replaces per-node hand-written stimulus and can be instantiated once per node for any mesh size.

Parameters:
DATA_WIDTH, 32, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the flit type (1 head, 2 body, 3 tail, 0 invalid).
NODE_ID, 0, this endpoint's node index; placed in payload bits [23:16] and checked against the head destination.
DEST_WIDTH, 3, width of the destination field in head flit bits [DEST_WIDTH-1:0].
LEN_WIDTH, 8, width of the packet-length and gap configuration fields.
CNT_WIDTH, 16, width of the packet and flit counters.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; latches cfg_* and begins generation; ignored while busy=1
cfg_dest  in  DEST_WIDTH  destination node for all packets of the run
cfg_len  in  LEN_WIDTH  flits per packet, including head and tail; values <2 treated as 2
cfg_num_pkts  in  CNT_WIDTH  packets in the run
cfg_gap  in  LEN_WIDTH  idle cycles between a tail handshake and the next head
tx_data  out  DATA_WIDTH  injected flit
tx_valid  out  1  injected flit valid
tx_ready  in  1  router accepts the flit
rx_data  in  DATA_WIDTH  ejected flit
rx_valid  in  1  ejected flit valid
rx_ready  out  1  endpoint accepts the flit; equals ~rx_stall
rx_stall  in  1  backpressure injection for test
busy  out  1  generator run in progress
done  out  1  one-cycle pulse after the last tail handshake
tx_pkt_count  out  CNT_WIDTH  packets fully sent in the current run
rx_pkt_count  out  CNT_WIDTH  tails received since reset
rx_flit_count  out  CNT_WIDTH  flits received since reset
rx_error  out  1  sticky framing/destination error

Behaviour:
- Reset: all outputs 0, except rx_ready = ~rx_stall. FSM returns to IDLE, counters clear, latched configuration clears. An asserted reset mid-packet aborts the packet immediately; no tail is sent.
- Generator FSM: IDLE, SEND, GAP, FIN.
- IDLE -> SEND on start. If cfg_num_pkts = 0, go IDLE -> FIN instead; done pulses the next cycle and no flits are sent.
- busy = 1 in SEND and GAP, and in FIN.
- Flit index f runs 1..len. f=1 is the head, f=len is the tail, all others are body flits.
- Head flit: type 1, zeros elsewhere, dest in [DEST_WIDTH-1:0].
- Body and tail flits: type 2 or 3. Bits [23:16] = NODE_ID, [15:8] = packet sequence (low 8 bits, starting at 0), [7:0] = f. All other bits are 0.
- Handshake: a transfer occurs when tx_valid & tx_ready are both high at the rising clk edge. tx_valid and tx_data are registered and stay stable until the transfer. tx_valid never deasserts mid-packet.
- First head tx_valid rises 1 cycle after start. After each transfer the next flit is presented in the following cycle (1 flit/cycle at full throughput).
- Tail transfer: tx_pkt_count increments. If packets remain, go SEND -> GAP, or go straight to SEND when cfg_gap = 0. Otherwise go SEND -> FIN.
- GAP: counts cfg_gap cycles with tx_valid = 0, then -> SEND.
- FIN: done = 1 for one cycle, busy drops, -> IDLE. tx_pkt_count holds until the next start, which clears it.
- Checker: a flit is accepted when rx_valid & rx_ready are both high; rx_flit_count increments on each accepted flit.
- Checker states: EXPECT_HEAD and IN_PKT.
- In EXPECT_HEAD, a head moves to IN_PKT. If the head's dest field ≠ NODE_ID[DEST_WIDTH-1:0], rx_error is set.
- In EXPECT_HEAD, a body or tail sets rx_error and the state is unchanged.
- In IN_PKT, a body keeps the state. A tail increments rx_pkt_count and moves to EXPECT_HEAD.
- In IN_PKT, a head sets rx_error and restarts the packet (stays IN_PKT).
- In any state, type 0 with rx_valid sets rx_error.
- rx_error clears only on reset.
- Counters wrap modulo 2^CNT_WIDTH without error.
- Generator and checker are independent; a loopback of tx to rx is legal.

Test Plan:
- Loopback tx->rx, NODE_ID=5, cfg_dest=5, len=6, num_pkts=2, gap=0, tx_ready=1 -> 12 consecutive flits. First flit 0x40000005, next 0x80050002; packet-0 tail 0xC0050006. done 13 cycles after start; rx_pkt_count=2, rx_flit_count=12, rx_error=0.
- tx_ready toggling 1/0 each cycle, len=4 -> tx_data is held while stalled, no flit is lost or duplicated, tail arrives on the 8th cycle, tx_pkt_count=1.
- gap=3, num_pkts=2 -> exactly 3 cycles with tx_valid=0 between the first tail handshake and the second head.
- cfg_len=1, num_pkts=0, start -> with num_pkts=0 done pulses and nothing is sent. Rerun with num_pkts=1 and cfg_len=1: exactly head + tail are sent.
- Driven rx: body flit with no preceding head -> rx_error=1, rx_pkt_count unchanged. Head with dest=4 at NODE_ID=5 -> rx_error=1. rx_stall=1 -> rx_ready=0 and counts frozen.
- Assert rst during the third flit of a packet -> all outputs 0 asynchronously. Next start produces a fresh head with sequence 0.
